// File: rtl/hash_rnd_pkg.sv
//==============================================================================
// hash_rnd_pkg
// Shared state encoding and helpers for the hash round sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

package hash_rnd_pkg;

    localparam int RND_STATE_W = 2;

    typedef enum logic [RND_STATE_W-1:0] {
        RND_IDLE = 2'b00,
        RND_RUN  = 2'b01,
        RND_DONE = 2'b10
    } rnd_state_t;

    // Number of enabled RUN cycles needed to walk from init_v to last_v inclusive.
    function automatic int rnd_len(input int init_v, input int last_v);
        return last_v - init_v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hash_round_sequencer_cnt.sv
//==============================================================================
// rnd_cnt_reg
// WIDTH-bit round register with synchronous clear, load-INIT and increment.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rnd_cnt_reg #(
    parameter int WIDTH = 3,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || load_i) begin
            cnt_d = INIT_V;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= INIT_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hash_round_sequencer.sv
//==============================================================================
// hash_round_sequencer
// Programmable round counter/sequencer pacing the hash round datapath.
// Optional abort port pair enabled by defining HASH_RND_ABORT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module hash_round_sequencer
    import hash_rnd_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LAST  = 5,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             start,
    input  logic             en,
`ifdef HASH_RND_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] round,
    output logic             co,
    output logic             busy,
    output logic             done
);

    if ((WIDTH < 2) || (WIDTH > 8) || (LAST >= (1 << WIDTH)) ||
        (INIT < 0) || (rnd_len(INIT, LAST) < 1)) begin : g_param_check
        $fatal(1, "hash_round_sequencer: illegal WIDTH/LAST/INIT combination");
    end

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    rnd_state_t       state_q;
    rnd_state_t       state_d;
    logic [WIDTH-1:0] round_q;
    logic             at_last;
    logic             abort_req;
    logic             cnt_load;
    logic             cnt_inc;
    logic             aborted_d;
    logic             aborted_q;

`ifdef HASH_RND_ABORT_EN
    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    assign at_last = (round_q == LAST_V);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RND_IDLE;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic; init overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            RND_IDLE: if (start) state_d = RND_RUN;
            RND_RUN: begin
                if (abort_req) begin
                    state_d = RND_IDLE;
                end else if (en && at_last) begin
                    state_d = RND_DONE;
                end
            end
            RND_DONE: state_d = RND_IDLE;
            default:  state_d = RND_IDLE;
        endcase
        if (init) begin
            state_d = RND_IDLE;
        end
    end

    // Output / datapath control decode
    always_comb begin
        cnt_inc   = (state_q == RND_RUN) && en && !abort_req && !at_last;
        cnt_load  = (state_d == RND_IDLE);
        aborted_d = (state_q == RND_RUN) && abort_req && !init;
        busy      = (state_q == RND_RUN);
        done      = (state_q == RND_DONE);
        co        = at_last && (state_q == RND_RUN);
    end

    rnd_cnt_reg #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_round_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (init),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .cnt_o  (round_q)
    );

    assign round = round_q;

`ifndef HASH_RND_ABORT_EN
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif

endmodule

`default_nettype wire
